// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit : multi-cycle multiply/divide unit owning the HI/LO registers of
//           the pipelined MIPS core.
//
// The unit accepts one operation at a time. The operation class sets how long
// busy stays high: MULT_LATENCY cycles for the multiply family and
// DIV_LATENCY cycles for divides. The result is computed in a single shot
// from operands captured at issue. It is written to HI/LO on the last busy
// cycle. A flush cancels the operation without touching HI/LO. mthi/mtlo
// write HI/LO directly, but only while the unit is idle.
//
// Parameters
//   WIDTH         operand and HI/LO width
//   MULT_LATENCY  busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU (>=1)
//   DIV_LATENCY   busy cycles for DIV/DIVU (>=1)
//
// Ports
//   clk       clock, rising edge
//   reset     synchronous, active-low reset
//   start     issue request
//   op        0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
//   a, b      operands rs, rt
//   flush     cancel the in-flight operation
//   write_hi  mthi strobe
//   write_lo  mtlo strobe
//   wdata     data for mthi/mtlo
//   busy      operation in flight
//   done      one-cycle pulse, hi/lo hold a new result
//   hi, lo    HI and LO registers
// ---------------------------------------------------------------------------
module md_unit #(
  parameter int WIDTH        = 32,
  parameter int MULT_LATENCY = 5,
  parameter int DIV_LATENCY  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 issue;

  logic [2:0]           op_p0;
  logic [WIDTH-1:0]     a_p0;
  logic [WIDTH-1:0]     b_p0;

  logic [2*WIDTH-1:0]   acc_p0;
  logic [2*WIDTH-1:0]   prod_p0;
  logic [2*WIDTH-1:0]   quot_p0;
  logic [2*WIDTH-1:0]   res_p0;
  logic                 sgn_p0;

  // Full-width product. The signed case sign-extends both factors and
  // multiplies in the signed domain. The low 2*WIDTH bits are exact.
  function automatic logic [2*WIDTH-1:0] mul_full(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             sgn
  );
    logic signed [2*WIDTH-1:0] xs;
    logic signed [2*WIDTH-1:0] ys;
    logic        [2*WIDTH-1:0] xu;
    logic        [2*WIDTH-1:0] yu;
    xs = $signed({{WIDTH{x[WIDTH-1]}}, x});
    ys = $signed({{WIDTH{y[WIDTH-1]}}, y});
    xu = {{WIDTH{1'b0}}, x};
    yu = {{WIDTH{1'b0}}, y};
    if (sgn) mul_full = xs * ys;
    else     mul_full = xu * yu;
  endfunction

  // Divide returning {remainder, quotient}. Signed divides run on the
  // magnitudes, then the quotient sign follows the operand signs and the
  // remainder sign follows the dividend. Divide-by-zero and the
  // most-negative / -1 overflow case have fixed, defined results.
  function automatic logic [2*WIDTH-1:0] div_full(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             sgn
  );
    logic [WIDTH-1:0] ax;
    logic [WIDTH-1:0] ay;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] min_neg;
    min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    if (y == '0) begin
      div_full = {x, {WIDTH{1'b1}}};
    end else if (sgn && (x == min_neg) && (y == {WIDTH{1'b1}})) begin
      div_full = {{WIDTH{1'b0}}, x};
    end else begin
      ax = (sgn && x[WIDTH-1]) ? -x : x;
      ay = (sgn && y[WIDTH-1]) ? -y : y;
      q  = ax / ay;
      r  = ax % ay;
      if (sgn && (x[WIDTH-1] ^ y[WIDTH-1])) q = -q;
      if (sgn && x[WIDTH-1])                r = -r;
      div_full = {r, q};
    end
  endfunction

  assign issue = (state == IDLE) && start && !flush;
  assign busy  = (state == BUSY);

  // ---- stage p0: operands captured at issue, held for the whole operation
  always_ff @(posedge clk) begin
    if (issue) begin
      op_p0 <= op;
      a_p0  <= a;
      b_p0  <= b;
    end
  end

  // op[0] selects unsigned. op[2:1] selects mult / div / madd / msub.
  always_comb begin
    sgn_p0  = ~op_p0[0];
    acc_p0  = {hi, lo};
    prod_p0 = mul_full(a_p0, b_p0, sgn_p0);
    quot_p0 = div_full(a_p0, b_p0, sgn_p0);
    res_p0  = prod_p0;
    case (op_p0[2:1])
      2'b00:   res_p0 = prod_p0;
      2'b01:   res_p0 = quot_p0;
      2'b10:   res_p0 = acc_p0 + prod_p0;
      default: res_p0 = acc_p0 - prod_p0;
    endcase
  end

  // ---- stage p1: control FSM, commit of HI/LO and the done pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            state <= BUSY;
            cnt   <= (op[2:1] == 2'b01) ? CNT_W'(DIV_LATENCY) : CNT_W'(MULT_LATENCY);
          end else begin
            if (write_hi) hi <= wdata;
            if (write_lo) lo <= wdata;
          end
        end
        default: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(1)) begin
            // Last busy cycle: commit now, so done lines up with the new HI/LO.
            state    <= IDLE;
            cnt      <= '0;
            done     <= 1'b1;
            {hi, lo} <= res_p0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
